// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// cdb_arbiter : one-slot-per-FU common data bus arbiter with registered output.
// CDB_ARB_RR_EN selects round-robin (default: fixed priority). Rev 1.0
// ============================================================================

package cdb_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] rd_v;
    logic [4:0]  rob_id;
  } cdb_entry_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 5,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][31:0] req_rd_v,
  input  logic [NUM_REQ-1:0][4:0]  req_rob_id,
  output logic [NUM_REQ-1:0]       req_ready,
  output cdb_entry_t               cdb,
  output logic [IDX_W-1:0]         grant_idx
);

  logic [NUM_REQ-1:0]       slot_valid_q, slot_valid_d;
  logic [NUM_REQ-1:0][31:0] slot_rd_v_q, slot_rd_v_d;
  logic [NUM_REQ-1:0][4:0]  slot_rob_id_q, slot_rob_id_d;
  cdb_entry_t               cdb_q, cdb_d;
  logic [IDX_W-1:0]         grant_idx_q, grant_idx_d;

  logic                     grant_any;
  logic [IDX_W-1:0]         grant_sel;
  logic [NUM_REQ-1:0]       grant;

`ifdef CDB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search begins at the pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_sel = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_any && slot_valid_q[IDX_W'(idx)]) begin
        grant_any = 1'b1;
        grant_sel = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (!flush && grant_any) begin
      ptr_d = (grant_sel == IDX_W'(NUM_REQ - 1)) ? '0 : grant_sel + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (slot_valid_q[IDX_W'(k)]) begin
        grant_any = 1'b1;
        grant_sel = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_sel] = 1'b1;
    end
  end

  // A granted slot empties at this edge, so it can take a new result at once.
  assign req_ready = {NUM_REQ{!flush}} & (~slot_valid_q | grant);

  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_rd_v_d   = slot_rd_v_q;
    slot_rob_id_d = slot_rob_id_q;
    cdb_d         = '0;
    grant_idx_d   = '0;
    if (flush) begin
      slot_valid_d = '0;
    end else begin
      if (grant_any) begin
        cdb_d.valid  = 1'b1;
        cdb_d.rd_v   = slot_rd_v_q[grant_sel];
        cdb_d.rob_id = slot_rob_id_q[grant_sel];
        grant_idx_d  = grant_sel;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          slot_valid_d[i]  = 1'b1;
          slot_rd_v_d[i]   = req_rd_v[i];
          slot_rob_id_d[i] = req_rob_id[i];
        end else if (grant[i]) begin
          slot_valid_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q  <= '0;
      slot_rd_v_q   <= '0;
      slot_rob_id_q <= '0;
      cdb_q         <= '0;
      grant_idx_q   <= '0;
    end else begin
      slot_valid_q  <= slot_valid_d;
      slot_rd_v_q   <= slot_rd_v_d;
      slot_rob_id_q <= slot_rob_id_d;
      cdb_q         <= cdb_d;
      grant_idx_q   <= grant_idx_d;
    end
  end

  assign cdb       = cdb_q;
  assign grant_idx = grant_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cdb_arbiter : directed and randomized checks of cdb_arbiter against a
// per-requester pending-entry model. Honours CDB_ARB_RR_EN. Rev 1.0
// ============================================================================

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 5;
`ifdef CDB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0][31:0] req_rd_v = '0;
  logic [N-1:0][4:0]  req_rob_id = '0;
  logic [N-1:0]       req_ready;
  cdb_entry_t         cdb;
  logic [2:0]         grant_idx;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_rd_v   (req_rd_v),
    .req_rob_id (req_rob_id),
    .req_ready  (req_ready),
    .cdb        (cdb),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  // Model: each requester holds at most one pending entry; a broadcast is
  // the pending entry chosen by the arbitration rule, visible one edge later.
  bit          pend_v[N];
  logic [31:0] pend_rd[N];
  logic [4:0]  pend_rob[N];
  int          m_ptr = 0;
  bit          exp_v = 1'b0;
  logic [31:0] exp_rd = '0;
  logic [4:0]  exp_rob = '0;
  int          exp_g = 0;

  bit cons_en = 1'b0;
  int n_acc = 0, n_drop = 0, n_cast = 0;
  int checks = 0, errors = 0;

  function automatic int pick();
    int r, idx;
    r = -1;
    for (int k = 0; k < N; k++) begin
      idx = RR ? (m_ptr + k) % N : k;
      if (r < 0 && pend_v[idx]) r = idx;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w, ca, cd;
    w  = pick();
    ca = 0;
    cd = 0;
    if (!rst_n || flush) begin
      for (int i = 0; i < N; i++) begin
        if (pend_v[i]) cd++;
        pend_v[i] <= 1'b0;
      end
      exp_v <= 1'b0;
      exp_g <= 0;
      if (!rst_n) m_ptr <= 0;
    end else begin
      exp_v <= (w >= 0);
      exp_g <= (w >= 0) ? w : 0;
      if (w >= 0) begin
        exp_rd  <= pend_rd[w];
        exp_rob <= pend_rob[w];
        m_ptr   <= (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && (!pend_v[i] || w == i)) begin
          pend_v[i]   <= 1'b1;
          pend_rd[i]  <= req_rd_v[i];
          pend_rob[i] <= req_rob_id[i];
          ca++;
        end else if (w == i) begin
          pend_v[i] <= 1'b0;
        end
      end
    end
    if (cons_en) begin
      n_acc  <= n_acc + ca;
      n_drop <= n_drop + cd;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    int w;
    logic [N-1:0] er;
    w = pick();
    for (int i = 0; i < N; i++) er[i] = !flush && (!pend_v[i] || w == i);
    chk("model req_ready", req_ready, er);
    chk("model cdb.valid", cdb.valid, exp_v);
    if (exp_v) begin
      chk("model cdb.rd_v", cdb.rd_v, exp_rd);
      chk("model cdb.rob_id", cdb.rob_id, exp_rob);
    end
    chk("model grant_idx", grant_idx, exp_g);
    if (cons_en && cdb.valid) n_cast++;
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Single alu handoff and reset values
    do_reset();
    chk("reset cdb", cdb, '0);
    chk("reset grant_idx", grant_idx, 0);
    req_valid[0]  = 1'b1;
    req_rd_v[0]   = 32'h12345678;
    req_rob_id[0] = 5'd3;
    #1;
    chk("ready after reset", req_ready, 5'h1f);
    tick();
    req_valid = '0;
    chk("alu latency valid", cdb.valid, 1'b0);
    tick();
    chk("alu cdb entry", cdb, {1'b1, 32'h12345678, 5'd3});
    chk("alu grant_idx", grant_idx, 0);
    tick();
    chk("alu cdb drained", cdb.valid, 1'b0);

    // All five requesters at once
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_rd_v[i]   = 32'hA000_0000 + i;
      req_rob_id[i] = 5'(i);
    end
    req_valid = '1;
    tick();
    req_valid = '0;
    for (int k = 0; k < N; k++) begin
      chk("all5 ready[4]", req_ready[4], (k == 4));
      tick();
      chk("all5 valid", cdb.valid, 1'b1);
      chk("all5 grant order", grant_idx, k);
      chk("all5 rob_id", cdb.rob_id, k);
    end
    tick();
    chk("all5 drained", cdb.valid, 1'b0);

    // alu and load continuously valid
    do_reset();
    req_valid[0] = 1'b1;
    req_valid[4] = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("alu/load valid", cdb.valid, 1'b1);
      chk("alu/load grant", grant_idx, RR ? ((k % 2 == 0) ? 0 : 4) : 0);
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();

    // Flush with slots 1,2 occupied and alu offering
    do_reset();
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    tick();
    req_valid    = '0;
    req_valid[0] = 1'b1;
    flush        = 1'b1;
    #1;
    chk("flush ready", req_ready, 5'h00);
    tick();
    flush     = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post-flush valid", cdb.valid, 1'b0);
    end

    // Back-to-back mult handoffs
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_valid[1]  = (k < 3);
      req_rob_id[1] = 5'(7 + k);
      #1;
      if (k < 3) chk("mult ready", req_ready[1], 1'b1);
      tick();
      if (k >= 1) begin
        chk("mult valid", cdb.valid, 1'b1);
        chk("mult rob_id", cdb.rob_id, 7 + k - 1);
      end
    end
    tick();
    chk("mult drained", cdb.valid, 1'b0);

    // Asynchronous reset mid-cycle with three slots full
    do_reset();
    req_valid = 5'b00111;
    tick();
    req_valid = 5'b00001;
    tick();
    req_valid = '0;
    chk("pre-reset valid", cdb.valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", cdb.valid, 1'b0);
    chk("async reset grant", grant_idx, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no stale after reset", cdb.valid, 1'b0);
    end

    // Randomized traffic with occasional flushes
    do_reset();
    cons_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int dens;
      dens = (c / 500) % 3;
      for (int i = 0; i < N; i++) begin
        req_valid[i]  = ($urandom_range(0, 3) <= dens);
        req_rd_v[i]   = $urandom;
        req_rob_id[i] = 5'($urandom_range(0, 31));
      end
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    req_valid = '0;
    flush     = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    cons_en = 1'b0;
    chk("entry conservation", n_acc, n_cast + n_drop);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
